// File: rtl/anubis_pkg.sv
// Shared Anubis definitions: GF(2^8) helper, block type and feeder state encoding.
package anubis_pkg;

  localparam logic [7:0]  ANUBIS_GF_POLY    = 8'h1D;
  localparam int unsigned ANUBIS_MAX_ROUNDS = 18;

  typedef logic [127:0] anubis_block_t;

  typedef enum logic {LOAD, READ} state_t;

  // Multiply by x modulo x^8+x^4+x^3+x^2+1.
  function automatic logic [7:0] gf_xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? ANUBIS_GF_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/anubis_theta.sv
// Anubis theta: each state row multiplied by the symmetric matrix H = had(01,02,04,06).
module anubis_theta
  import anubis_pkg::*;
(
  input  anubis_block_t i_key,
  output anubis_block_t o_key
);

  logic [7:0] w_a;
  logic [7:0] w_x2;
  logic [7:0] w_x4;
  logic [7:0] w_acc;

  // H[k][j] depends only on k^j: 0->01, 1->02, 2->04, 3->06.
  always_comb begin
    o_key = '0;
    w_a   = '0;
    w_x2  = '0;
    w_x4  = '0;
    w_acc = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      for (int unsigned j = 0; j < 4; j++) begin
        w_acc = '0;
        for (int unsigned k = 0; k < 4; k++) begin
          w_a  = i_key[127 - 8*(4*i + k) -: 8];
          w_x2 = gf_xtime(w_a);
          w_x4 = gf_xtime(w_x2);
          case (2'(k ^ j))
            2'd0:    w_acc = w_acc ^ w_a;
            2'd1:    w_acc = w_acc ^ w_x2;
            2'd2:    w_acc = w_acc ^ w_x4;
            default: w_acc = w_acc ^ w_x4 ^ w_x2;
          endcase
        end
        o_key[127 - 8*(4*i + j) -: 8] = w_acc;
      end
    end
  end

endmodule

// File: rtl/anubis_dec_key_feeder.sv
// Buffers a forward Anubis key schedule and replays it in decryption order.
// Define ANUBIS_DEC_THETA_EN to apply theta to the middle keys inside the feeder.
module anubis_dec_key_feeder
  import anubis_pkg::*;
#(
  parameter int unsigned MAX_ROUNDS = ANUBIS_MAX_ROUNDS
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  anubis_block_t wr_key,
  input  logic          wr_last,
  output logic          rd_valid,
  input  logic          rd_ready,
  output anubis_block_t rd_key,
  output logic          rd_first,
  output logic          rd_last,
  output logic          err_ovf
);

  localparam int unsigned PW = $clog2(MAX_ROUNDS + 1);
  localparam int unsigned IW = $clog2(MAX_ROUNDS + 2);
  localparam logic [PW-1:0] LAST_PTR = PW'(MAX_ROUNDS);

  anubis_block_t r_mem [0:MAX_ROUNDS];

  state_t        r_state;
  logic          r_wr_ready;
  logic          r_rd_valid;
  logic [PW-1:0] r_wr_ptr;
  logic [IW-1:0] r_count;
  logic [PW-1:0] r_rd_idx;
  logic          r_err_ovf;

  logic          w_wr_fire;
  logic          w_rd_fire;
  logic          w_wr_final;
  logic [IW-1:0] w_top_idx;
  logic          w_is_top;
  anubis_block_t w_raw;
  anubis_block_t w_key;

  assign w_wr_fire  = wr_valid && r_wr_ready && !clr;
  assign w_rd_fire  = rd_ready && r_rd_valid && !clr;
  assign w_wr_final = wr_last || (r_wr_ptr == LAST_PTR);
  assign w_top_idx  = r_count - IW'(1);
  assign w_is_top   = (IW'(r_rd_idx) == w_top_idx);
  assign w_raw      = r_mem[r_rd_idx];

`ifdef ANUBIS_DEC_THETA_EN
  anubis_block_t w_theta;
  logic          w_mid;

  anubis_theta u_theta (
    .i_key (w_raw),
    .o_key (w_theta)
  );

  // First and last decryption keys bypass theta; with count<=2 no index is "middle".
  assign w_mid = (r_rd_idx != '0) && !w_is_top;
  assign w_key = w_mid ? w_theta : w_raw;
`else
  assign w_key = w_raw;
`endif

  assign wr_ready = r_wr_ready;
  assign rd_valid = r_rd_valid;
  assign err_ovf  = r_err_ovf;
  assign rd_key   = r_rd_valid ? w_key : '0;
  assign rd_first = r_rd_valid && w_is_top;
  assign rd_last  = r_rd_valid && (r_rd_idx == '0);

  always_ff @(posedge clk) begin
    if (rst_n && w_wr_fire)
      r_mem[r_wr_ptr] <= wr_key;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      r_state    <= LOAD;
      r_wr_ready <= 1'b1;
      r_rd_valid <= 1'b0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_rd_idx   <= '0;
      r_err_ovf  <= 1'b0;
    end else begin
      case (r_state)
        LOAD: begin
          if (w_wr_fire) begin
            r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_wr_final) begin
              r_count    <= IW'(r_wr_ptr) + IW'(1);
              r_rd_idx   <= r_wr_ptr;
              r_state    <= READ;
              r_wr_ready <= 1'b0;
              r_rd_valid <= 1'b1;
              if (!wr_last)
                r_err_ovf <= 1'b1;
            end
          end
        end
        READ: begin
          if (w_rd_fire) begin
            if (r_rd_idx == '0)
              r_rd_idx <= PW'(w_top_idx);
            else
              r_rd_idx <= r_rd_idx - PW'(1);
          end
        end
        default: begin
          r_state    <= LOAD;
          r_wr_ready <= 1'b1;
          r_rd_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_anubis_dec_key_feeder.sv
// Directed bench for anubis_dec_key_feeder; tracks ANUBIS_DEC_THETA_EN to pick expectations.
module tb_anubis_dec_key_feeder;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         clr = 1'b0;
  logic         wr_valid = 1'b0;
  logic         wr_ready;
  logic [127:0] wr_key = '0;
  logic         wr_last = 1'b0;
  logic         rd_valid;
  logic         rd_ready = 1'b0;
  logic [127:0] rd_key;
  logic         rd_first;
  logic         rd_last;
  logic         err_ovf;

  int n_cmp = 0;
  int n_err = 0;

  logic [127:0] m_mem [0:18];
  int           m_count;
  int           m_idx;

  always #5 clk = ~clk;

  anubis_dec_key_feeder #(.MAX_ROUNDS(18)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_key   (wr_key),
    .wr_last  (wr_last),
    .rd_valid (rd_valid),
    .rd_ready (rd_ready),
    .rd_key   (rd_key),
    .rd_first (rd_first),
    .rd_last  (rd_last),
    .err_ovf  (err_ovf)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

`ifdef ANUBIS_DEC_THETA_EN
  localparam logic [7:0] H [4][4] = '{'{8'h01, 8'h02, 8'h04, 8'h06},
                                      '{8'h02, 8'h01, 8'h06, 8'h04},
                                      '{8'h04, 8'h06, 8'h01, 8'h02},
                                      '{8'h06, 8'h04, 8'h02, 8'h01}};

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = '0;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int n = 0; n < 8; n++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1D) : {x[6:0], 1'b0};
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [127:0] theta_m(input logic [127:0] x);
    logic [127:0] b = '0;
    logic [7:0]   acc;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        acc = '0;
        for (int k = 0; k < 4; k++)
          acc = acc ^ gmul(x[127 - 8*(4*i + k) -: 8], H[k][j]);
        b[127 - 8*(4*i + j) -: 8] = acc;
      end
    return b;
  endfunction
`endif

  function automatic logic [127:0] exp_key(input int idx);
`ifdef ANUBIS_DEC_THETA_EN
    if (idx > 0 && idx < m_count - 1)
      return theta_m(m_mem[idx]);
`endif
    return m_mem[idx];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr1(input logic [127:0] key, input logic last);
    check("wr_ready_load", {127'd0, wr_ready}, 128'd1);
    wr_valid = 1'b1;
    wr_key   = key;
    wr_last  = last;
    tick();
    wr_valid = 1'b0;
    wr_last  = 1'b0;
  endtask

  task automatic load(input int n, input logic [7:0] base, input logic use_last,
                      input logic exp_ovf);
    logic [127:0] k;
    for (int i = 0; i < n; i++) begin
      k = {16{8'(i) + base}};
      m_mem[i] = k;
      wr1(k, use_last && (i == n - 1));
    end
    m_count = n;
    m_idx   = n - 1;
    check("rd_valid_after_load", {127'd0, rd_valid}, 128'd1);
    check("wr_ready_after_load", {127'd0, wr_ready}, 128'd0);
    check("err_ovf_after_load", {127'd0, err_ovf}, {127'd0, exp_ovf});
  endtask

  task automatic read_seq(input int n, input logic toggle);
    logic rdy;
    for (int c = 0; c < n; c++) begin
      rdy = toggle ? (c % 2 == 0) : 1'b1;
      rd_ready = rdy;
      check("rd_valid", {127'd0, rd_valid}, 128'd1);
      check("rd_key", rd_key, exp_key(m_idx));
      check("rd_first", {127'd0, rd_first}, {127'd0, m_idx == m_count - 1});
      check("rd_last", {127'd0, rd_last}, {127'd0, m_idx == 0});
      tick();
      if (rdy) m_idx = (m_idx == 0) ? m_count - 1 : m_idx - 1;
    end
    rd_ready = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_wr_ready"}, {127'd0, wr_ready}, 128'd1);
    check({tag, "_rd_valid"}, {127'd0, rd_valid}, 128'd0);
    check({tag, "_rd_first"}, {127'd0, rd_first}, 128'd0);
    check({tag, "_rd_last"},  {127'd0, rd_last},  128'd0);
    check({tag, "_err_ovf"},  {127'd0, err_ovf},  128'd0);
    check({tag, "_rd_key"},   rd_key, 128'd0);
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [127:0] theta_exp;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    check_idle("reset");

    // R=12 schedule, straight read then backpressured replay across the wrap
    load(13, 8'h00, 1'b1, 1'b0);
    check("r0_const", rd_key, {16{8'h0C}});
    read_seq(13, 1'b0);
    check("wrap_first", {127'd0, rd_first}, 128'd1);
    read_seq(30, 1'b1);

    // hand-computed theta vector on a middle key
    pulse_clr();
    check_idle("clr_read");
    m_mem[0] = {16{8'hAA}};
    m_mem[1] = 128'h01000000_00000000_00000000_00000000;
    m_mem[2] = {16{8'h55}};
    wr1(m_mem[0], 1'b0);
    wr1(m_mem[1], 1'b0);
    wr1(m_mem[2], 1'b1);
    m_count = 3;
    m_idx   = 2;
    read_seq(1, 1'b0);
`ifdef ANUBIS_DEC_THETA_EN
    theta_exp = 128'h01020406_00000000_00000000_00000000;
`else
    theta_exp = 128'h01000000_00000000_00000000_00000000;
`endif
    check("theta_vec", rd_key, theta_exp);
    read_seq(5, 1'b0);

    // overflow: 19 keys with no wr_last
    pulse_clr();
    check_idle("clr_ovf");
    load(19, 8'h20, 1'b0, 1'b1);
    check("ovf_r0", rd_key, {16{8'h32}});
    read_seq(20, 1'b0);
    check("ovf_sticky", {127'd0, err_ovf}, 128'd1);

    // single key replays unchanged
    pulse_clr();
    check_idle("clr_single");
    m_mem[0] = 128'h0123456789ABCDEF_FEDCBA9876543210;
    wr1(m_mem[0], 1'b1);
    m_count = 1;
    m_idx   = 0;
    read_seq(4, 1'b0);
    check("single_key", rd_key, 128'h0123456789ABCDEF_FEDCBA9876543210);
    check("single_flags", {126'd0, rd_first, rd_last}, 128'd3);

    // clr mid-READ, then reset mid-LOAD, then a fresh schedule
    pulse_clr();
    load(13, 8'h00, 1'b1, 1'b0);
    read_seq(5, 1'b0);
    pulse_clr();
    check_idle("clr_mid_read");
    wr1({16{8'hEE}}, 1'b0);
    wr1({16{8'hDD}}, 1'b0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_idle("rst_mid_load");
    load(13, 8'h80, 1'b1, 1'b0);
    read_seq(13, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
